io_in_debounce: RTL and testbench

- Input-conditioning stage directly upstream of tiny_user_project.
- Takes raw, asynchronous pad inputs `io_in` from the Caravel harness.
- Synchronises each bit, then debounces it with a per-bit persistence counter.
- Drives the clean levels, plus single-cycle rise/fall pulses and a saturating transition counter, into the user project.

---
 rtl/io_in_debounce.sv | 129 ++++++++++++
 tb/tb_io_in_debounce.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_in_debounce.sv
// io_in_debounce: pad input conditioning ahead of the user project.
// Each io_in bit is synchronised, then debounced with its own persistence
// counter. The block also produces registered rise/fall pulses and a
// saturating count of accepted transitions across all bits.
module io_in_debounce #(
  parameter int WIDTH           = 38,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [WIDTH-1:0] io_in,
  input  logic             bypass_i,
  input  logic             clear_cnt_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] stable_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [CNT_W-1:0] trans_cnt_o
);

  // A debounce counter never has to hold more than DEBOUNCE_CYCLES-1.
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam int PC_W  = $clog2(WIDTH + 1);
  // Wide enough that the sum cannot wrap before the saturation test.
  localparam int SUM_W = CNT_W + PC_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
  logic [WIDTH-1:0] stable_reg, stable_next;
  logic [WIDTH-1:0] rise_reg, fall_reg;
  logic [WIDTH-1:0] edge_any;
  logic [PC_W-1:0]  edge_pop;
  logic [SUM_W-1:0] cnt_sum;
  logic [CNT_W-1:0] trans_cnt_reg, trans_cnt_next;

  // Synchroniser chain: plain flop-to-flop, nothing between stages.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        // First stage captures the asynchronous pads.
        always_ff @(posedge wb_clk_i) begin
          if (wb_rst_i) sync_reg[gi] <= '0;
          else          sync_reg[gi] <= io_in;
        end
      end else begin : g_rest
        // Later stages only shift the previous stage.
        always_ff @(posedge wb_clk_i) begin
          if (wb_rst_i) sync_reg[gi] <= '0;
          else          sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign sync_o = sync_reg[SYNC_STAGES-1];

  // Per-bit persistence counters deciding when a new level is accepted.
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [DB_W-1:0] db_cnt_reg, db_cnt_next;
      logic            stable_bit_next;

      // Count consecutive mismatch cycles; accept on the last one, and any
      // match (or bypass) throws away a partial count.
      always_comb begin
        db_cnt_next     = '0;
        stable_bit_next = stable_reg[gi];
        if (bypass_i) begin
          stable_bit_next = sync_o[gi];
        end else if (sync_o[gi] != stable_reg[gi]) begin
          if (db_cnt_reg == DB_LAST) stable_bit_next = sync_o[gi];
          else                       db_cnt_next     = db_cnt_reg + DB_W'(1);
        end
      end

      // Debounce counter register.
      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) db_cnt_reg <= '0;
        else          db_cnt_reg <= db_cnt_next;
      end

      assign stable_next[gi] = stable_bit_next;
    end
  endgenerate

  // Stable level plus edge pulses, registered together so a pulse lines up
  // with the first cycle the new level is visible.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stable_reg <= '0;
      rise_reg   <= '0;
      fall_reg   <= '0;
    end else begin
      stable_reg <= stable_next;
      rise_reg   <= stable_next & ~stable_reg;
      fall_reg   <= ~stable_next & stable_reg;
    end
  end

  assign edge_any = rise_reg | fall_reg;

  // Popcount of the pulses currently visible, then saturating add; clear wins.
  always_comb begin
    edge_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      edge_pop = edge_pop + PC_W'(edge_any[i]);
    end
    cnt_sum = SUM_W'(trans_cnt_reg) + SUM_W'(edge_pop);
    if (clear_cnt_i)                    trans_cnt_next = '0;
    else if (cnt_sum > SUM_W'(CNT_MAX)) trans_cnt_next = CNT_MAX;
    else                                trans_cnt_next = cnt_sum[CNT_W-1:0];
  end

  // Transition counter register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) trans_cnt_reg <= '0;
    else          trans_cnt_reg <= trans_cnt_next;
  end

  assign stable_o    = stable_reg;
  assign rise_o      = rise_reg;
  assign fall_o      = fall_reg;
  assign trans_cnt_o = trans_cnt_reg;

endmodule

// File: tb/tb_io_in_debounce.sv
// tb_io_in_debounce: scoreboard bench for io_in_debounce. A behavioural
// model predicts every output for each clock edge; predictions are queued
// when stimulus is applied and compared once the edge has happened.
// Directed checks cover the fixed latencies and boundary cases.
module tb_io_in_debounce;
  localparam int W  = 38;
  localparam int S  = 2;
  localparam int D  = 4;
  localparam int CW = 16;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic [W-1:0]  io_in;
  logic          bypass_i;
  logic          clear_cnt_i;
  logic [W-1:0]  sync_o, stable_o, rise_o, fall_o;
  logic [CW-1:0] trans_cnt_o;

  io_in_debounce #(
    .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .CNT_W(CW)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .io_in      (io_in),
    .bypass_i   (bypass_i),
    .clear_cnt_i(clear_cnt_i),
    .sync_o     (sync_o),
    .stable_o   (stable_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .trans_cnt_o(trans_cnt_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct packed {
    logic [W-1:0]  sync;
    logic [W-1:0]  stable;
    logic [W-1:0]  rise;
    logic [W-1:0]  fall;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  logic [W-1:0]  m_pipe [S];
  logic [W-1:0]  m_stable, m_rise, m_fall;
  logic [CW-1:0] m_cnt;
  int            m_age [W];

  logic [W-1:0]  ones = '1;
  logic [W-1:0]  rise_seen, fall_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic [W-1:0] s_old, st_new;
    int sum;
    if (wb_rst_i) begin
      for (int k = 0; k < S; k++) m_pipe[k] = '0;
      m_stable = '0; m_rise = '0; m_fall = '0; m_cnt = '0;
      for (int i = 0; i < W; i++) m_age[i] = 0;
    end else begin
      s_old  = m_pipe[S-1];
      st_new = m_stable;
      for (int i = 0; i < W; i++) begin
        if (bypass_i) begin
          st_new[i] = s_old[i];
          m_age[i]  = 0;
        end else if (s_old[i] == m_stable[i]) begin
          m_age[i] = 0;
        end else begin
          m_age[i]++;
          if (m_age[i] == D) begin
            st_new[i] = s_old[i];
            m_age[i]  = 0;
          end
        end
      end
      if (clear_cnt_i) m_cnt = '0;
      else begin
        sum   = int'(m_cnt) + $countones(m_rise | m_fall);
        m_cnt = (sum > 65535) ? 16'hFFFF : sum[15:0];
      end
      m_rise   = st_new & ~m_stable;
      m_fall   = ~st_new & m_stable;
      m_stable = st_new;
      for (int k = S - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = io_in;
    end
  endtask

  // One clock: queue the prediction, take the edge, compare against the DUT.
  task automatic step();
    exp_t e;
    model_edge();
    e.sync = m_pipe[S-1]; e.stable = m_stable; e.rise = m_rise;
    e.fall = m_fall;      e.cnt = m_cnt;
    sb_q.push_back(e);
    @(posedge wb_clk_i);
    #1;
    e = sb_q.pop_front();
    check("sb_sync",   sync_o,      e.sync);
    check("sb_stable", stable_o,    e.stable);
    check("sb_rise",   rise_o,      e.rise);
    check("sb_fall",   fall_o,      e.fall);
    check("sb_cnt",    trans_cnt_o, e.cnt);
    rise_seen |= rise_o;
    fall_seen |= fall_o;
  endtask

  task automatic cycles(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  initial begin
    logic [7:0] pat;
    logic       hist [0:15];
    logic       exp_f;

    wb_rst_i = 1'b1; bypass_i = 1'b0; clear_cnt_i = 1'b0; io_in = '1;
    rise_seen = '0; fall_seen = '0;

    // Reset with pads high, then release
    cycles(3);
    check("rst_stable", stable_o, 0);
    check("rst_cnt", trans_cnt_o, 0);
    wb_rst_i = 1'b0;
    step();
    check("rel_sync1", sync_o, 0);
    step();
    check("rel_sync2", sync_o, ones);
    cycles(3);
    check("rel_stable_early", stable_o, 0);
    step();
    check("rel_stable", stable_o, ones);
    check("rel_rise", rise_o, ones);
    step();
    check("rel_rise_end", rise_o, 0);
    check("rel_cnt38", trans_cnt_o, 38);

    // Settle low, clear counter
    io_in = '0;
    cycles(10);
    clear_cnt_i = 1'b1; step(); clear_cnt_i = 1'b0;
    check("clr_cnt", trans_cnt_o, 0);

    // Short pulse on bit 5 is rejected
    rise_seen = '0; fall_seen = '0;
    io_in[5] = 1'b1; cycles(3);
    io_in[5] = 1'b0; cycles(8);
    check("rej_stable5", stable_o[5], 0);
    check("rej_pulse5", rise_seen[5] | fall_seen[5], 0);
    check("rej_cnt", trans_cnt_o, 0);

    // Held level on bit 5 is accepted after the full latency
    io_in[5] = 1'b1;
    cycles(5);
    check("acc_stable5_early", stable_o[5], 0);
    step();
    check("acc_stable5", stable_o[5], 1);
    check("acc_rise5", rise_o[5], 1);
    step();
    check("acc_rise5_end", rise_o[5], 0);
    check("acc_cnt", trans_cnt_o, 1);

    // Glitch on bit 0 restarts the count
    pat = 8'b1111_0111;
    for (int j = 0; j < 8; j++) begin
      io_in[0] = pat[j];
      step();
    end
    step();
    check("glitch_stable0_early", stable_o[0], 0);
    step();
    check("glitch_stable0", stable_o[0], 1);

    // Bypass: bit 37 toggling every cycle
    bypass_i = 1'b1;
    hist[0] = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      io_in[37] = j[0];
      hist[j] = j[0];
      step();
      if (j >= 3) begin
        exp_f = ~hist[j-2];
        check("byp_stable37", stable_o[37], hist[j-2]);
        check("byp_rise37", rise_o[37], hist[j-2]);
        check("byp_fall37", fall_o[37], exp_f);
      end
    end
    cycles(4);

    // Counter preload, saturation and clear
    clear_cnt_i = 1'b1; step(); clear_cnt_i = 1'b0;
    check("sat_clr", trans_cnt_o, 0);
    for (int k = 0; k < 1724; k++) begin
      io_in = ~io_in;
      step();
    end
    cycles(4);
    check("sat_preload", trans_cnt_o, 16'hFFE8);
    io_in = io_in ^ 38'h3FFFFF; step(); cycles(4);
    check("sat_fffe", trans_cnt_o, 16'hFFFE);
    io_in = io_in ^ 38'h3; step(); cycles(4);
    check("sat_ffff", trans_cnt_o, 16'hFFFF);
    io_in = io_in ^ 38'h1; step(); cycles(4);
    check("sat_hold", trans_cnt_o, 16'hFFFF);
    io_in = io_in ^ 38'h7;
    cycles(3);
    check("clr_pulses", $countones(rise_o | fall_o), 3);
    clear_cnt_i = 1'b1; step(); clear_cnt_i = 1'b0;
    check("clr_win", trans_cnt_o, 0);
    cycles(3);
    check("clr_stay", trans_cnt_o, 0);

    // Reset mid-debounce on bit 3 discards the partial count
    bypass_i = 1'b0;
    io_in = '0;
    cycles(10);
    io_in[3] = 1'b1;
    cycles(4);
    wb_rst_i = 1'b1; step(); wb_rst_i = 1'b0;
    check("mid_rst_stable", stable_o, 0);
    cycles(5);
    check("mid_stable3_early", stable_o[3], 0);
    step();
    check("mid_stable3", stable_o[3], 1);
    check("mid_rise3", rise_o[3], 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
